router_fsm: RTL and testbench

ROUTER_FSM -- requirements
Module: router_fsm

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_fsm.sv | 79 +++++++
 tb/tb_router_fsm.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg: state encoding and destination address constants shared by the router control logic.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        CHECK_PARITY_ERROR = 3'd4,
        FIFO_FULL_STATE    = 3'd5,
        LOAD_AFTER_FULL    = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    localparam logic [1:0] ADDR0        = 2'd0;
    localparam logic [1:0] ADDR1        = 2'd1;
    localparam logic [1:0] ADDR2        = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm.sv
// router_fsm: packet router control FSM; steers header decode, payload/parity loads,
// full-FIFO stalls and per-FIFO soft resets, with Moore decodes of the current state.
module router_fsm
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic [1:0] addr_q
);

    state_t     state, next;
    logic [3:0] empty_vec, soft_vec;
    logic       hdr_ok, empty_in, empty_q, soft_q;

    // Padding the vectors to four entries keeps the invalid address index in range.
    assign empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign hdr_ok    = pkt_valid && data_in != ADDR_INVALID;
    assign empty_in  = empty_vec[data_in];
    assign empty_q   = empty_vec[addr_q];
    assign soft_q    = soft_vec[addr_q];

    always_comb begin
        next = DECODE_ADDRESS;
        case (state)
            DECODE_ADDRESS:     next = !hdr_ok ? DECODE_ADDRESS : empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            WAIT_TILL_EMPTY:    next = empty_q ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:    next = LOAD_DATA;
            LOAD_DATA:          next = fifo_full ? FIFO_FULL_STATE : !pkt_valid ? LOAD_PARITY : LOAD_DATA;
            LOAD_PARITY:        next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE:    next = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:    next = parity_done ? DECODE_ADDRESS : low_packet_valid ? LOAD_PARITY : LOAD_DATA;
            default:            next = DECODE_ADDRESS;
        endcase
        if (state != DECODE_ADDRESS && soft_q)
            next = DECODE_ADDRESS;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= DECODE_ADDRESS;
            addr_q <= ADDR0;
        end else begin
            state <= next;
            if (state == DECODE_ADDRESS && hdr_ok)
                addr_q <= data_in;
        end
    end

    assign detect_add    = state == DECODE_ADDRESS;
    assign lfd_state     = state == LOAD_FIRST_DATA;
    assign ld_state      = state == LOAD_DATA;
    assign laf_state     = state == LOAD_AFTER_FULL;
    assign full_state    = state == FIFO_FULL_STATE;
    assign rst_int_reg   = state == CHECK_PARITY_ERROR;
    assign write_enb_reg = state == LOAD_DATA || state == LOAD_PARITY || state == LOAD_AFTER_FULL;
    assign busy          = !(state == DECODE_ADDRESS || state == LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed scoreboard bench; each step queues the expected output decode
// and address, then the post-edge sample is popped and checked.
module tb_router_fsm;
    import router_pkg::*;

    logic       clock = 0, reset = 0, pkt_valid = 0, fifo_full = 0;
    logic [1:0] data_in = 0, addr_q;
    logic       fifo_empty_0 = 1, fifo_empty_1 = 1, fifo_empty_2 = 1;
    logic       soft_reset_0 = 0, soft_reset_1 = 0, soft_reset_2 = 0;
    logic       parity_done = 0, low_packet_valid = 0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy;

    typedef struct {
        logic [9:0] v;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0;

    router_fsm dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg),
        .busy(busy), .addr_q(addr_q)
    );

    always #5 clock = ~clock;

    // Expected {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy,addr_q} for a state.
    function automatic logic [9:0] exp_of(state_t s, logic [1:0] a);
        logic [7:0] d;
        case (s)
            DECODE_ADDRESS:     d = 8'b1000_0000;
            LOAD_FIRST_DATA:    d = 8'b0100_0001;
            LOAD_DATA:          d = 8'b0010_0010;
            LOAD_PARITY:        d = 8'b0000_0011;
            CHECK_PARITY_ERROR: d = 8'b0000_0101;
            FIFO_FULL_STATE:    d = 8'b0000_1001;
            LOAD_AFTER_FULL:    d = 8'b0001_0011;
            default:            d = 8'b0000_0001;
        endcase
        return {d, a};
    endfunction

    task automatic step(input string tag, input state_t s, input logic [1:0] a);
        exp_t e, got;
        logic [9:0] obs;
        e.v   = exp_of(s, a);
        e.tag = tag;
        q.push_back(e);
        @(posedge clock);
        #1;
        got = q.pop_front();
        obs = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, busy, addr_q};
        tests++;
        assert (obs === got.v) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.v);
        end
    endtask

    initial begin
        reset = 1;
        step("reset", DECODE_ADDRESS, 0);
        reset = 0;
        step("idle_hold", DECODE_ADDRESS, 0);

        pkt_valid = 1; data_in = 1;
        step("p1_lfd", LOAD_FIRST_DATA, 1);
        step("p1_ld", LOAD_DATA, 1);
        step("p1_ld_hold", LOAD_DATA, 1);
        pkt_valid = 0;
        step("p1_lp", LOAD_PARITY, 1);
        step("p1_cpe", CHECK_PARITY_ERROR, 1);
        step("p1_done", DECODE_ADDRESS, 1);

        pkt_valid = 1; data_in = 2;
        step("p2_lfd", LOAD_FIRST_DATA, 2);
        step("p2_ld", LOAD_DATA, 2);
        pkt_valid = 0;
        step("p2_lp", LOAD_PARITY, 2);
        step("p2_cpe", CHECK_PARITY_ERROR, 2);
        step("p2_done", DECODE_ADDRESS, 2);

        pkt_valid = 1; data_in = 3;
        step("invalid_addr", DECODE_ADDRESS, 2);
        pkt_valid = 0; data_in = 1;
        step("no_valid", DECODE_ADDRESS, 2);

        pkt_valid = 1; data_in = 0;
        step("p3_lfd", LOAD_FIRST_DATA, 0);
        step("p3_ld", LOAD_DATA, 0);
        fifo_full = 1;
        step("p3_full", FIFO_FULL_STATE, 0);
        pkt_valid = 0;
        step("p3_full_hold", FIFO_FULL_STATE, 0);
        fifo_full = 0;
        step("p3_laf", LOAD_AFTER_FULL, 0);
        pkt_valid = 1;
        step("p3_laf_to_ld", LOAD_DATA, 0);
        fifo_full = 1; pkt_valid = 0;
        step("full_priority", FIFO_FULL_STATE, 0);
        fifo_full = 0;
        step("p3_laf2", LOAD_AFTER_FULL, 0);
        low_packet_valid = 1;
        step("laf_lpv", LOAD_PARITY, 0);
        low_packet_valid = 0; fifo_full = 1;
        step("lp_uncond", CHECK_PARITY_ERROR, 0);
        step("cpe_full", FIFO_FULL_STATE, 0);
        fifo_full = 0;
        step("p3_laf3", LOAD_AFTER_FULL, 0);
        parity_done = 1; low_packet_valid = 1;
        step("laf_parity_done", DECODE_ADDRESS, 0);
        parity_done = 0; low_packet_valid = 0;

        pkt_valid = 1; data_in = 0; fifo_empty_0 = 0;
        step("wte", WAIT_TILL_EMPTY, 0);
        pkt_valid = 0; soft_reset_1 = 1; soft_reset_2 = 1;
        step("wte_other_soft", WAIT_TILL_EMPTY, 0);
        soft_reset_1 = 0; soft_reset_2 = 0; soft_reset_0 = 1;
        step("wte_soft", DECODE_ADDRESS, 0);
        soft_reset_0 = 0; pkt_valid = 1;
        step("wte2", WAIT_TILL_EMPTY, 0);
        fifo_empty_0 = 1; pkt_valid = 0;
        step("wte_to_lfd", LOAD_FIRST_DATA, 0);
        pkt_valid = 1;
        step("p4_ld", LOAD_DATA, 0);
        soft_reset_0 = 1;
        step("ld_soft", DECODE_ADDRESS, 0);
        soft_reset_0 = 0;

        data_in = 2; fifo_empty_2 = 1;
        step("p5_lfd", LOAD_FIRST_DATA, 2);
        step("p5_ld", LOAD_DATA, 2);
        fifo_full = 1;
        step("p5_full", FIFO_FULL_STATE, 2);
        soft_reset_2 = 1;
        step("full_soft", DECODE_ADDRESS, 2);
        soft_reset_2 = 0; fifo_full = 0;
        step("p6_lfd", LOAD_FIRST_DATA, 2);
        step("p6_ld", LOAD_DATA, 2);
        reset = 1;
        step("reset_mid_ld", DECODE_ADDRESS, 0);
        reset = 0; data_in = 1;
        step("p7_lfd", LOAD_FIRST_DATA, 1);
        step("p7_ld", LOAD_DATA, 1);
        fifo_full = 1;
        step("p7_full", FIFO_FULL_STATE, 1);
        reset = 1; soft_reset_1 = 1; fifo_full = 0;
        step("reset_in_full", DECODE_ADDRESS, 0);
        reset = 0; soft_reset_1 = 0; pkt_valid = 0;
        step("post_reset_idle", DECODE_ADDRESS, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
